conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator that sits directly upstream of the convolution datapath. It accepts a raster-order pixel stream of `IN_CH` channels per beat and buffers `KH-1` image rows. For each valid (unpadded, stride-1) position it emits one `IN_CH x KH x KW` patch, in exactly the layout the convolution stage consumes. Valid/ready handshakes on both sides allow full-rate operation and lossless backpressure.

## Interface
- `IN_CH`, 1: channels per pixel beat.
- `KH`, 3: kernel height, at least 1.
- `KW`, 3: kernel width, at least 1.
- `DATA_WIDTH`, 16: signed sample width.
- `IMG_W`, 8: image width in pixels, at least `KW`.
- `IMG_H`, 8: image height in rows, at least `KH`.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_pix` in `[IN_CH][DATA_WIDTH]` signed: one pixel, all channels.
- `in_valid` in 1: `in_pix` is valid.
- `in_ready` out 1: the block accepts `in_pix` this cycle.
- `out_patch` out `[IN_CH][KH][KW][DATA_WIDTH]` signed: the window.
  - `ky=0` is the top (oldest) row.
  - `kx=0` is the leftmost column.
- `out_valid` out 1: `out_patch` is valid.
- `out_ready` in 1: downstream takes the patch this cycle.
- `out_last` out 1: qualifies the final window of the frame.

## Operation
- **Input transfer:** occurs on `in_valid && in_ready`. Pixels arrive in raster order, row 0 col 0 first.
- **Position counters:** `col` counts 0..`IMG_W-1` and `row` counts 0..`IMG_H-1`.
  - `col` advances per transfer.
  - At `col == IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At the last pixel of the frame, both wrap to 0; the next frame follows with no gap cycles.
- **Line buffer:** per column `c`, hold the `KH-1` previous-row samples. On transfer at column `c`:
  - the new column vector is {stored[c][0..KH-2], `in_pix`};
  - stored[c] shifts up by one and `in_pix` is written at the bottom.
- **Window register:** `KH x KW x IN_CH`.
  - On each transfer it shifts left one column.
  - The new column vector enters at `kx=KW-1`.
- **Window emission:** a window is complete when the accepted pixel has `row >= KH-1` and `col >= KW-1`.
  - On that transfer, `out_patch` loads the shifted window and `out_valid` is set the next cycle.
  - Stale data from the previous row or frame never reaches a valid output, because emission is gated by the counters.
- **Frame output count:** `(IMG_H-KH+1)*(IMG_W-KW+1)` windows.
- **`out_last`:** high with the window produced by pixel (`IMG_H-1`, `IMG_W-1`).
- **Backpressure:** `in_ready = !out_valid || out_ready`. While `in_ready` is low, no input is taken.
- **Output stability:** `out_patch` and `out_last` are stable while `out_valid && !out_ready`.
- **`out_valid` clearing:** cleared after a handshake unless the same-cycle input transfer completes a new window. In that case it stays high with new data.
- **Reset:** clears `out_valid`, `out_last`, `out_patch`, `row` and `col` to 0.
  - Line-buffer contents need not be cleared.
  - Reset mid-frame discards the partial frame; the next accepted pixel is row 0 col 0.

## Timing
- Latency: 1 cycle from the completing input transfer to `out_valid`.
- Throughput: one pixel per cycle when `out_ready` is held high. Windows are produced on every qualifying pixel.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- All outputs are 0 or low in the cycle after `rst` is asserted. `in_ready` is high in that cycle.

## Structure
- **Shared package `cnn_pkg`:**
  - `pixel_t`: signed `DATA_WIDTH`.
  - A helper function returning the counter width, `$clog2` of a dimension with a minimum of 1.
- **Sub-module `conv_line_buffer`:**
  - Parameters: `IN_CH`, `KH`, `IMG_W`, `DATA_WIDTH`.
  - Inputs: write-enable, column index, pixel.
  - Output: the `KH`-tall column vector, combinational read-before-write.
- **Top level:** holds the counters, window shift register, output register and handshake.

## Test plan
- **Basic 4x4 frame:** `IN_CH=1`, `K=3`, `IMG_W=IMG_H=4`, pixel = `4*row+col`, `out_ready` held at 1.
  - Exactly 4 windows.
  - First window after the 11th input, rows {0,1,2},{4,5,6},{8,9,10}.
  - Last window is {5,6,7},{9,10,11},{13,14,15} with `out_last=1`; `out_last=0` on the others.
- **Backpressure:** hold `out_ready=0` for 5 cycles on the first window.
  - `out_patch` stays stable and `in_ready=0`.
  - After release, the remaining windows match the no-stall run exactly, with no loss or duplication.
- **Back-to-back frames:** two frames with continuous `in_valid`; the second frame uses pixel+100.
  - 8 windows total.
  - Frame-2 first window is {100,101,102},{104,105,106},{108,109,110}.
  - No frame-1 data appears in any frame-2 window.
- **Reset mid-frame:** assert `rst` one cycle after the 6th pixel.
  - `out_valid=0` and `in_ready=1` the next cycle.
  - A fresh frame afterwards yields exactly 4 correct windows.
- **Multichannel, random stalls:** `IN_CH=2`, channel1 = -channel0, random `in_valid`/`out_ready`.
  - Every window equals the reference-model patch per channel.
  - Negative values are preserved.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and sizing helpers for the CNN streaming blocks
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    // Counter width for a dimension; a dimension of 1 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - per-column store of the KH-1 previous rows, read-before-write
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int IN_CH      = 1,
    parameter int KH         = 3,
    parameter int IMG_W      = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                          clk,
    input  logic                                          we_i,
    input  logic [cnt_width(IMG_W)-1:0]                   col_i,
    input  logic [IN_CH-1:0][DATA_WIDTH-1:0]              pix_i,
    output logic [KH-1:0][IN_CH-1:0][DATA_WIDTH-1:0]      col_vec_o
);

    generate
        if (KH > 1) begin : g_buf
            // Index 0 holds the oldest row; the newest stored row sits at KH-2.
            logic [KH-2:0][IN_CH-1:0][DATA_WIDTH-1:0] mem_q [IMG_W];

            always_ff @(posedge clk) begin
                if (we_i) begin
                    for (int k = 0; k < KH - 2; k++) begin
                        mem_q[col_i][k] <= mem_q[col_i][k+1];
                    end
                    mem_q[col_i][KH-2] <= pix_i;
                end
            end

            assign col_vec_o = {pix_i, mem_q[col_i]};
        end else begin : g_pass
            assign col_vec_o = pix_i;
        end
    endgenerate

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster-stream to KH x KW sliding-window patch generator
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int IN_CH      = 1,
    parameter int KH         = 3,
    parameter int KW         = 3,
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic signed [IN_CH-1:0][DATA_WIDTH-1:0]               in_pix,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    output logic signed [IN_CH-1:0][KH-1:0][KW-1:0][DATA_WIDTH-1:0] out_patch,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic                                                  out_last
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KH - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          valid_q;
    logic          last_q;
    logic [IN_CH-1:0][KH-1:0][KW-1:0][DATA_WIDTH-1:0] win_q, win_d, patch_q;
    logic [KH-1:0][IN_CH-1:0][DATA_WIDTH-1:0]         col_vec;

    logic xfer, emit, frame_end;

    assign in_ready  = !valid_q || out_ready;
    assign xfer      = in_valid && in_ready;
    assign emit      = xfer && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    assign frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

    conv_line_buffer #(
        .IN_CH      (IN_CH),
        .KH         (KH),
        .IMG_W      (IMG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk       (clk),
        .we_i      (xfer),
        .col_i     (col_q),
        .pix_i     (in_pix),
        .col_vec_o (col_vec)
    );

    always_comb begin
        win_d = win_q;
        for (int ch = 0; ch < IN_CH; ch++) begin
            for (int ky = 0; ky < KH; ky++) begin
                for (int kx = 0; kx < KW - 1; kx++) begin
                    win_d[ch][ky][kx] = win_q[ch][ky][kx+1];
                end
                win_d[ch][ky][KW-1] = col_vec[ky][ch];
            end
        end
    end

    // The window register is never emitted until the counters qualify it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            patch_q <= '0;
        end else begin
            if (xfer) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (emit) begin
                valid_q <= 1'b1;
                last_q  <= frame_end;
                patch_q <= win_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_patch = patch_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen on a 4x4, 2-channel frame
module tb_conv_window_gen;
    import cnn_pkg::*;

    typedef logic [1:0][2:0][2:0][15:0] patch_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0][15:0] in_pix;
    logic          in_valid;
    logic          in_ready;
    patch_t        out_patch;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int cmp_cnt = 0;
    int err_cnt = 0;

    patch_t exp_q[$];
    bit     exp_last_q[$];
    patch_t seen_q[$];
    int     nwin, nlast;
    int     img[4][4];
    int     m_row, m_col;
    bit     hold;
    patch_t hold_patch;
    logic   hold_last;
    bit     rnd_mode = 1'b0;

    conv_window_gen #(
        .IN_CH(2), .KH(3), .KW(3), .DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_patch (out_patch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic patch_t mk(input int r, input int c);
        patch_t p;
        int v;
        for (int ch = 0; ch < 2; ch++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++) begin
                    v = img[r-2+ky][c-2+kx];
                    p[ch][ky][kx] = (ch == 0) ? 16'(v) : 16'(-v);
                end
        return p;
    endfunction

    function automatic patch_t mk_const(input int a[9]);
        patch_t p;
        for (int ch = 0; ch < 2; ch++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    p[ch][ky][kx] = (ch == 0) ? 16'(a[ky*3+kx]) : 16'(-a[ky*3+kx]);
        return p;
    endfunction

    // Monitor: pops the scoreboard on every output handshake and watches stalls.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else if (out_valid) begin
            if (hold) begin
                check("stall_patch_stable", out_patch, hold_patch);
                check("stall_last_stable", out_last, hold_last);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    check("patch", out_patch, exp_q.pop_front());
                    check("last", out_last, exp_last_q.pop_front());
                end
                seen_q.push_back(out_patch);
                nwin++;
                if (out_last) nlast++;
                hold = 1'b0;
            end else begin
                check("stall_in_ready", in_ready, 0);
                hold       = 1'b1;
                hold_patch = out_patch;
                hold_last  = out_last;
            end
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        exp_last_q.delete();
        seen_q.delete();
        nwin  = 0;
        nlast = 0;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pix   = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_last", out_last, 0);
        check("rst_out_patch", out_patch, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_pixel(input int v, input int gap);
        bit ok;
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_pix[0] = 16'(v);
        in_pix[1] = 16'(-v);
        in_valid  = 1'b1;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) begin
            check("input_accept_timeout", 1, 0);
        end else begin
            img[m_row][m_col] = v;
            if (m_row >= 2 && m_col >= 2) begin
                exp_q.push_back(mk(m_row, m_col));
                exp_last_q.push_back(m_row == 3 && m_col == 3);
            end
            if (m_col == 3) begin
                m_col = 0;
                m_row = (m_row == 3) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int a[9];
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        model_reset();
        reset_dut();

        // Basic frame, full rate, with first-window latency checks.
        for (int i = 0; i < 16; i++) begin
            send_pixel(i, 0);
            if (i == 9)  check("no_window_after_10", out_valid, 0);
            if (i == 10) check("window_after_11", out_valid, 1);
        end
        drain();
        check("basic_count", nwin, 4);
        check("basic_last_count", nlast, 1);
        a = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        if (seen_q.size() > 0) check("basic_first", seen_q[0], mk_const(a));
        a = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        if (seen_q.size() > 3) check("basic_final", seen_q[3], mk_const(a));

        // Backpressure on the first window.
        reset_dut();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_pixel(i, 0);
                in_valid = 1'b0;
            end
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_window_seen", out_valid, 1);
                a = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold_patch", out_patch, mk_const(a));
                    check("stall_hold_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", nwin, 4);
        check("bp_last_count", nlast, 1);

        // Two frames back to back, second offset by 100.
        reset_dut();
        for (int i = 0; i < 32; i++) send_pixel((i < 16) ? i : i - 16 + 100, 0);
        drain();
        check("b2b_count", nwin, 8);
        check("b2b_last_count", nlast, 2);
        a = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        if (seen_q.size() > 4) check("b2b_frame2_first", seen_q[4], mk_const(a));

        // Reset one cycle after the sixth pixel, then a fresh frame.
        reset_dut();
        for (int i = 0; i < 6; i++) send_pixel(i + 200, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();
        for (int i = 0; i < 16; i++) send_pixel(i + 50, 0);
        drain();
        check("midrst_count", nwin, 4);
        a = '{50, 51, 52, 54, 55, 56, 58, 59, 60};
        if (seen_q.size() > 0) check("midrst_first", seen_q[0], mk_const(a));

        // Random gaps and random downstream stalls, signed data.
        reset_dut();
        rnd_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) send_pixel(-1234, 0);
            else send_pixel(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2)));
        end
        drain();
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("rand_count", nwin, 8);
        check("rand_last_count", nlast, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
